// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 8-digit seven-segment scan controller.
// Optional build macro SEG_LZS_EN (leading-zero suppression) is consumed in seg_scan_ctrl.
package seg_scan_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned DIGIT_W    = 3;
    localparam int unsigned HEX_W      = 4;
    localparam int unsigned DATA_W     = 5;
    localparam int unsigned SEG_W      = 8;
    localparam int unsigned BLANK_W    = 4;
    localparam int unsigned BLINK_W    = 8;

    localparam logic [SEG_W-1:0]      SEG_BLANK = 8'hFF;
    localparam logic [NUM_DIGITS-1:0] CS_NONE   = 8'hFF;

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } state_e;

    typedef struct packed {
        logic             dot;
        logic [HEX_W-1:0] hex;
    } digit_t;

    // Active-low one-hot digit select for digit index idx.
    function automatic logic [NUM_DIGITS-1:0] cs_onehot(input logic [DIGIT_W-1:0] idx);
        logic [NUM_DIGITS-1:0] one;
        one = NUM_DIGITS'(1);
        return ~(one << idx);
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex-to-segment table, active-low {dp,g,f,e,d,c,b,a}.
module seg_hex_decode
    import seg_scan_pkg::*;
(
    input  logic [HEX_W-1:0] hex_i,
    input  logic             dot_i,
    output logic [SEG_W-1:0] seg_o_c
);

    logic [SEG_W-2:0] glyph;

    always_comb begin
        glyph = 7'h7F;
        case (hex_i)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            4'hF: glyph = 7'h0E;
            default: glyph = 7'h7F;
        endcase
    end

    assign seg_o_c = {~dot_i, glyph};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scanner with dead-time, per-digit blink and frame tick.
// Define SEG_LZS_EN to suppress leading zero digits (digit 0 always shown).
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int unsigned BLANK_TICKS       = 1,
    parameter int unsigned BLINK_HALF_FRAMES = 32
) (
    input  logic        clk_1kHz,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [4:0]  wr_data,
    input  logic        scan_en,
    input  logic [7:0]  blink_mask,
    output logic [7:0]  cs,
    output logic [7:0]  seg,
    output logic        frame_done
);

    state_e               state_q, state_d;
    logic [BLANK_W-1:0]   blank_cnt_q, blank_cnt_d;
    logic [DIGIT_W-1:0]   slot_q, slot_d;
    logic [DIGIT_W-1:0]   ptr_q, ptr_d;
    logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                 blink_phase_q, blink_phase_d;
    digit_t               digit_q [NUM_DIGITS];
    digit_t               digit_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] cs_q, cs_d;
    logic [SEG_W-1:0]     seg_q, seg_d;
    logic                 frame_done_q, frame_done_d;

    logic                 enter_show;
    logic [DIGIT_W-1:0]   show_idx;
    logic [SEG_W-1:0]     dec_seg;
    logic [NUM_DIGITS-1:0] lzs_sup;
    logic                 suppress;

    // Digit register file: a write lands at the edge, so same-edge reads see the old value.
    always_comb begin
        digit_d = digit_q;
        if (wr_en) begin
            digit_d[wr_addr] = digit_t'(wr_data);
        end
    end

    // Scan enable is sampled at the slot boundary; a disabled scan pins the pointer to digit 0.
    assign show_idx = scan_en ? ptr_q : DIGIT_W'(0);

    seg_hex_decode u_dec (
        .hex_i   (digit_q[show_idx].hex),
        .dot_i   (digit_q[show_idx].dot),
        .seg_o_c (dec_seg)
    );

`ifdef SEG_LZS_EN
    // Leading-zero run from digit 7 downward; digit 0 is never part of it.
    always_comb begin
        logic zero_run;
        lzs_sup  = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run   = zero_run & (digit_q[k] == '0);
            lzs_sup[k] = zero_run;
        end
    end
`else
    assign lzs_sup = '0;
`endif

    assign suppress = (blink_phase_q & blink_mask[show_idx]) | lzs_sup[show_idx];

    // State register.
    always_ff @(posedge clk_1kHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BLANK;
            blank_cnt_q   <= '0;
            slot_q        <= '0;
            ptr_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            cs_q          <= CS_NONE;
            seg_q         <= SEG_BLANK;
            frame_done_q  <= 1'b0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                digit_q[k] <= '0;
            end
        end else begin
            state_q       <= state_d;
            blank_cnt_q   <= blank_cnt_d;
            slot_q        <= slot_d;
            ptr_q         <= ptr_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            cs_q          <= cs_d;
            seg_q         <= seg_d;
            frame_done_q  <= frame_done_d;
            digit_q       <= digit_d;
        end
    end

    // Next-state: one show cycle, BLANK_TICKS dead cycles, then the next slot.
    always_comb begin
        state_d       = state_q;
        blank_cnt_d   = blank_cnt_q;
        slot_d        = slot_q;
        ptr_d         = ptr_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        enter_show    = 1'b0;

        unique case (state_q)
            ST_SHOW: begin
                if (BLANK_TICKS == 0) begin
                    enter_show = 1'b1;
                end else begin
                    state_d     = ST_BLANK;
                    blank_cnt_d = BLANK_W'(BLANK_TICKS - 1);
                end
            end
            ST_BLANK: begin
                if (blank_cnt_q == '0) begin
                    enter_show = 1'b1;
                end else begin
                    blank_cnt_d = blank_cnt_q - BLANK_W'(1);
                end
            end
        endcase

        if (enter_show) begin
            state_d = ST_SHOW;
            slot_d  = slot_q + DIGIT_W'(1);
            ptr_d   = scan_en ? (ptr_q + DIGIT_W'(1)) : DIGIT_W'(0);
            // Blink counts frame ticks; the new phase applies from the following slot.
            if (slot_q == DIGIT_W'(NUM_DIGITS - 1)) begin
                if (blink_cnt_q == BLINK_W'(BLINK_HALF_FRAMES - 1)) begin
                    blink_cnt_d   = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                end
            end
        end
    end

    // Output decode, registered on the edge that enters the next state.
    always_comb begin
        cs_d         = CS_NONE;
        seg_d        = SEG_BLANK;
        frame_done_d = 1'b0;
        if (enter_show) begin
            cs_d         = cs_onehot(show_idx);
            seg_d        = suppress ? SEG_BLANK : dec_seg;
            frame_done_d = (slot_q == DIGIT_W'(NUM_DIGITS - 1));
        end
    end

    assign cs         = cs_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter BLANK_TICKS, default 1: dead-time cycles between digit slots, range 0..15.
REQ-002 SHALL have parameter BLINK_HALF_FRAMES, default 32: frames per blink half-period, range 1..255.
REQ-003 SHALL have port clk_1kHz, input, 1: scan clock; all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port wr_en, input, 1: digit register write strobe.
REQ-006 SHALL have port wr_addr, input, 3: digit index 0..7.
REQ-007 SHALL have port wr_data, input, 5: {dot, hex[3:0]}.
REQ-008 SHALL have port scan_en, input, 1: 1 = scan digits 0..7, 0 = hold digit 0.
REQ-009 SHALL have port blink_mask, input, 8: bit k=1 makes digit k blink.
REQ-010 SHALL have port cs, output, 8: one-hot active-low digit select.
REQ-011 SHALL have port seg, output, 8: {dp,g,f,e,d,c,b,a}, active-low.
REQ-012 SHALL have port frame_done, output, 1: one-cycle frame tick.

Function
REQ-013 SHALL hold eight 5-bit digit registers; wr_en=1 at an edge writes wr_data to register wr_addr at that edge.
REQ-014 SHALL run FSM {ST_SHOW, ST_BLANK}: ST_SHOW lasts 1 cycle, then ST_BLANK for BLANK_TICKS cycles, then ST_SHOW of next slot; BLANK_TICKS=0 SHALL give back-to-back ST_SHOW.
REQ-015 SHALL register cs/seg: on the edge entering ST_SHOW of digit k, cs <= ~(8'b1<<k), seg <= decode(reg[k]); on the edge entering ST_BLANK, cs <= 8'hFF, seg <= 8'hFF.
REQ-016 SHALL use the pre-edge register value when a write to digit k coincides with the edge entering ST_SHOW of k; new value SHALL appear on that digit's next slot.
REQ-017 SHALL advance pointer 7 -> 0 wrap when scan_en=1; when scan_en=0, every slot SHALL show digit 0; a scan_en change SHALL take effect at the next slot boundary.
REQ-018 SHALL keep a free-running 3-bit slot counter independent of scan_en; frame_done SHALL be 1 for exactly the ST_SHOW cycle of slot 7.
REQ-019 SHALL toggle blink_phase after every BLINK_HALF_FRAMES frame ticks; when blink_phase=1 and blink_mask[k]=1, seg SHALL be 8'hFF during digit k's slot, cs still asserted.
REQ-020 SHALL decode hex 0..F to standard active-low patterns (0->C0, 1->F9, 8->80, A->88, F->8E) with dp = ~dot (digit 8 with dot -> 8'h00).

Reset
REQ-021 SHALL, while rst_n=0, force cs=8'hFF, seg=8'hFF, frame_done=0, all digit registers 0, pointer 0, slot counter 0, blink counter 0, blink_phase 0, FSM to ST_BLANK with blank counter expired.
REQ-022 SHALL enter ST_SHOW of digit 0 on the first edge after rst_n deasserts; reset mid-slot SHALL abort the slot immediately.

Configuration
REQ-023 SHALL implement leading-zero suppression when macro SEG_LZS_EN is defined: scanning from digit 7 down, digits with hex=0 and dot=0 SHALL show seg=8'hFF until the first non-qualifying digit; digit 0 is never suppressed.
REQ-024 SHALL, without SEG_LZS_EN, display every digit's decoded value; port list identical in both builds.

Structure
REQ-025 SHALL place state_e, digit_t {dot, hex}, SEG_BLANK=8'hFF, CS_NONE=8'hFF in package seg_scan_pkg.
REQ-026 SHALL implement the hex-to-segment table as combinational sub-module seg_hex_decode, instantiated once.

Verification
REQ-027 Reset, release, BLANK_TICKS=1, scan_en=1, all registers 0 -> cs sequence FE,FF,FD,FF,...,7F,FF,FE; seg C0 during each ST_SHOW.
REQ-028 Write reg3=5'h1A on the ST_SHOW edge of digit 3 -> that slot seg=C0, next frame digit 3 seg=08.
REQ-029 scan_en=0 -> cs=FE every ST_SHOW; frame_done still pulses every 16 cycles.
REQ-030 blink_mask=8'h04, BLINK_HALF_FRAMES=2 -> digit 2 seg FF for frames 2-3, normal frames 0-1 and 4-5; cs=FB throughout.
REQ-031 SEG_LZS_EN, registers 7..0 = 0,0,0,0,0,1,2,3 -> digits 7..3 seg FF, digits 2..0 F9/A4/B0; all zero -> only digit 0 shows C0.
REQ-032 rst_n low for 1 cycle mid ST_SHOW of digit 5 -> cs=FF/seg=FF immediately, next post-release edge cs=FE.
